// File: rtl/notch_coeff_apb_regs_if.sv
// APB slave bus bundle for the notch coefficient register bank.
interface notch_coeff_apb_regs_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/notch_coeff_apb_regs.sv
// APB register bank for the IIR notch filter: shadow coefficients committed atomically to the
// active set on a filter sample strobe (or immediately when the filter is disabled).
module notch_coeff_apb_regs #(
  parameter int unsigned width  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  notch_coeff_apb_regs_if.slave apb,
  input  logic                  sample_en,
  output logic [5*width-1:0]    filter_coeff,
  output logic                  filter_en,
  output logic                  bypass
);

  localparam int unsigned WW = ADDR_W - 2;
  localparam logic [WW-1:0] WCtrl   = WW'(0);
  localparam logic [WW-1:0] WShB0   = WW'(1);
  localparam logic [WW-1:0] WShA2   = WW'(5);
  localparam logic [WW-1:0] WStatus = WW'(6);
  localparam logic [WW-1:0] WActB0  = WW'(8);
  localparam logic [WW-1:0] WActA2  = WW'(12);

  // 1.0 in S.(width-2) fixed point.
  localparam logic [width-1:0] CoefOne = {2'b01, {(width - 2){1'b0}}};

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e           state_q;
  logic             en_q;
  logic             byp_q;
  logic [7:0]       cnt_q;
  logic [width-1:0] shadow_q [5];
  logic [width-1:0] active_q [5];

  logic [WW-1:0] word;
  logic [2:0]    idx;
  logic          access, wr;
  logic          sel_ctrl, sel_shadow, sel_status, sel_active, unmapped;
  logic          wr_err, commit_req, commit_fire;
  logic [31:0]   rd_data;
  logic          unused_bits;

  function automatic logic [31:0] sext(input logic [width-1:0] v);
    return {{(32 - width){v[width-1]}}, v};
  endfunction

  assign word   = apb.PADDR[ADDR_W-1:2];
  assign access = apb.PSEL & apb.PENABLE;
  assign wr     = access & apb.PWRITE;

  always_comb begin
    sel_ctrl   = (word == WCtrl);
    sel_status = (word == WStatus);
    sel_shadow = (word >= WShB0) && (word <= WShA2);
    sel_active = (word >= WActB0) && (word <= WActA2);
    unmapped   = !(sel_ctrl || sel_status || sel_shadow || sel_active);
    idx        = '0;
    if (sel_shadow) begin
      idx = 3'(word - WShB0);
    end else if (sel_active) begin
      idx = 3'(word - WActB0);
    end
  end

  // Shadow is frozen while a commit is pending so the set being committed stays consistent.
  assign wr_err      = unmapped | sel_status | sel_active | (sel_shadow & (state_q == StPending));
  assign commit_req  = wr & sel_ctrl & apb.PWDATA[2];
  assign commit_fire = (state_q == StPending) & (sample_en | ~en_q);

  always_comb begin
    rd_data = '0;
    if (sel_ctrl) begin
      rd_data = {30'd0, byp_q, en_q};
    end else if (sel_shadow) begin
      rd_data = sext(shadow_q[idx]);
    end else if (sel_status) begin
      rd_data = {16'd0, cnt_q, 7'd0, state_q == StPending};
    end else if (sel_active) begin
      rd_data = sext(active_q[idx]);
    end
  end

  assign apb.PREADY  = access;
  assign apb.PSLVERR = access & (apb.PWRITE ? wr_err : unmapped);
  assign apb.PRDATA  = (access && !apb.PWRITE) ? rd_data : '0;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      en_q    <= 1'b0;
      byp_q   <= 1'b1;
      cnt_q   <= '0;
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= (i == 0) ? CoefOne : '0;
        active_q[i] <= (i == 0) ? CoefOne : '0;
      end
    end else begin
      if (wr && sel_ctrl) begin
        en_q  <= apb.PWDATA[0];
        byp_q <= apb.PWDATA[1];
      end
      if (wr && sel_shadow && (state_q == StIdle)) begin
        shadow_q[idx] <= apb.PWDATA[width-1:0];
      end
      unique case (state_q)
        StIdle: begin
          if (commit_req) state_q <= StPending;
        end
        StPending: begin
          if (commit_fire) begin
            for (int i = 0; i < 5; i++) active_q[i] <= shadow_q[i];
            cnt_q   <= cnt_q + 8'd1;
            state_q <= commit_req ? StPending : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign filter_coeff = {active_q[0], active_q[1], active_q[2], active_q[3], active_q[4]};
  assign filter_en    = en_q;
  assign bypass       = byp_q;

  assign unused_bits = ^{apb.PWDATA[31:width], apb.PADDR[1:0]};

endmodule

// File: tb/tb_notch_coeff_apb_regs.sv
// Scoreboard bench for notch_coeff_apb_regs: APB responses checked by a monitor, filter-side
// outputs checked directly against hand-computed values.
module tb_notch_coeff_apb_regs;
  localparam int unsigned Width = 16;
  localparam int unsigned AddrW = 8;
  localparam logic [79:0] CoefReset = 80'h4000_0000_0000_0000_0000;
  localparam logic [79:0] CoefSetA  = 80'h3E00_8400_3E00_8500_3C00;
  localparam logic [79:0] CoefSetB  = 80'h3E00_8400_0005_8000_3C00;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic [79:0] filter_coeff;
  logic        filter_en;
  logic        bypass;

  notch_coeff_apb_regs_if #(.ADDR_W(AddrW)) apb ();

  notch_coeff_apb_regs #(
    .width (Width),
    .ADDR_W(AddrW)
  ) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .apb         (apb),
    .sample_en   (sample_en),
    .filter_coeff(filter_coeff),
    .filter_en   (filter_en),
    .bypass      (bypass)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic w, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
    exp_t e;
    e.rd   = exp_rd;
    e.err  = exp_err;
    e.name = name;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = w;
    apb.PADDR   = addr;
    apb.PWDATA  = wdata;
    @(posedge CLK); #1;
    apb.PENABLE = 1'b1;
    @(posedge CLK); #1;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] d, input logic err,
                        input string name);
    apb_xfer(1'b1, addr, d, 32'h0, err, name);
  endtask

  task automatic rd_reg(input logic [7:0] addr, input logic [31:0] exp, input logic err,
                        input string name);
    apb_xfer(1'b0, addr, 32'h0, exp, err, name);
  endtask

  // Monitor: every completed APB transfer is matched against the oldest expected response.
  always @(negedge CLK) begin
    exp_t e;
    if (apb.PREADY === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transfer: PREADY=1 with no transfer outstanding");
      end else begin
        e = exp_q.pop_front();
        if (apb.PRDATA !== e.rd || apb.PSLVERR !== e.err) begin
          errors++;
          $display("FAIL %s: got PRDATA=%h PSLVERR=%b, expected PRDATA=%h PSLVERR=%b",
                   e.name, apb.PRDATA, apb.PSLVERR, e.rd, e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    sample_en   = 1'b0;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK) rst_n = 1'b1;

    // Reset state
    check("reset_coeff", filter_coeff, CoefReset);
    check("reset_bypass", 80'(bypass), 80'd1);
    check("reset_en", 80'(filter_en), 80'd0);
    check("idle_pready", 80'(apb.PREADY), 80'd0);
    check("idle_prdata", 80'(apb.PRDATA), 80'd0);
    rd_reg(8'h18, 32'h0000_0000, 1'b0, "reset_status");
    rd_reg(8'h00, 32'h0000_0002, 1'b0, "reset_ctrl");
    rd_reg(8'h20, 32'h0000_4000, 1'b0, "reset_act_b0");
    rd_reg(8'h04, 32'h0000_4000, 1'b0, "reset_sh_b0");

    // Atomic commit with filter running
    wr_reg(8'h00, 32'h1, 1'b0, "ctrl_en");
    check("en_after_write", 80'(filter_en), 80'd1);
    check("byp_after_write", 80'(bypass), 80'd0);
    wr_reg(8'h04, 32'h3E00, 1'b0, "wr_b0");
    wr_reg(8'h08, 32'h8400, 1'b0, "wr_b1");
    wr_reg(8'h0C, 32'h3E00, 1'b0, "wr_b2");
    wr_reg(8'h10, 32'h8500, 1'b0, "wr_a1");
    wr_reg(8'h14, 32'h3C00, 1'b0, "wr_a2");
    rd_reg(8'h08, 32'hFFFF_8400, 1'b0, "sh_b1_sext");
    wr_reg(8'h00, 32'h5, 1'b0, "ctrl_commit_run");
    repeat (10) @(posedge CLK);
    #1;
    check("hold_coeff", filter_coeff, CoefReset);
    rd_reg(8'h18, 32'h0000_0001, 1'b0, "status_pending");

    // Protection while pending
    wr_reg(8'h04, 32'h1234, 1'b1, "sh_wr_pending");
    rd_reg(8'h04, 32'h0000_3E00, 1'b0, "sh_b0_kept");
    wr_reg(8'h00, 32'h5, 1'b0, "ctrl_recommit");
    wr_reg(8'h18, 32'hFFFF, 1'b1, "wr_status");
    rd_reg(8'h40, 32'h0, 1'b1, "rd_unmapped_40");
    rd_reg(8'h20, 32'h0000_4000, 1'b0, "act_b0_pending");
    check("still_old_coeff", filter_coeff, CoefReset);

    sample_en = 1'b1;
    @(posedge CLK); #1;
    sample_en = 1'b0;
    check("commit_coeff", filter_coeff, CoefSetA);
    rd_reg(8'h18, 32'h0000_0100, 1'b0, "status_cnt1");
    rd_reg(8'h24, 32'hFFFF_8400, 1'b0, "act_b1");
    wr_reg(8'h20, 32'h1, 1'b1, "wr_active");
    rd_reg(8'h1C, 32'h0, 1'b1, "rd_unmapped_1c");
    rd_reg(8'h20, 32'h0000_3E00, 1'b0, "act_b0_unchanged");

    // Sign extension and upper-bit masking
    wr_reg(8'h10, 32'hFFFF_8000, 1'b0, "wr_a1_neg");
    rd_reg(8'h10, 32'hFFFF_8000, 1'b0, "a1_sext");
    wr_reg(8'h0C, 32'h1234_0005, 1'b0, "wr_b2_upper");
    rd_reg(8'h0C, 32'h0000_0005, 1'b0, "b2_masked");

    // Commit with filter disabled: one edge after the write, no strobe
    wr_reg(8'h00, 32'h4, 1'b0, "ctrl_commit_dis");
    check("dis_coeff_before", filter_coeff, CoefSetA);
    @(posedge CLK); #1;
    check("dis_coeff_after", filter_coeff, CoefSetB);
    check("dis_en", 80'(filter_en), 80'd0);
    check("dis_byp", 80'(bypass), 80'd0);
    rd_reg(8'h18, 32'h0000_0200, 1'b0, "status_cnt2");

    // COMMIT_CNT wrap after 256 commits
    for (int i = 0; i < 254; i++) begin
      wr_reg(8'h00, 32'h4, 1'b0, "ctrl_commit_loop");
    end
    rd_reg(8'h18, 32'h0000_0000, 1'b0, "status_wrap");

    // Reset while pending
    wr_reg(8'h00, 32'h5, 1'b0, "ctrl_commit_prerst");
    rd_reg(8'h18, 32'h0000_0001, 1'b0, "status_prerst");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_coeff", filter_coeff, CoefReset);
    repeat (2) @(posedge CLK);
    @(negedge CLK) rst_n = 1'b1;
    check("rst_coeff", filter_coeff, CoefReset);
    check("rst_bypass", 80'(bypass), 80'd1);
    check("rst_en", 80'(filter_en), 80'd0);
    rd_reg(8'h18, 32'h0000_0000, 1'b0, "rst_status");
    rd_reg(8'h10, 32'h0000_0000, 1'b0, "rst_sh_a1");
    rd_reg(8'h00, 32'h0000_0002, 1'b0, "rst_ctrl");
    repeat (3) @(posedge CLK);
    #1;
    check("rst_coeff_later", filter_coeff, CoefReset);

    repeat (2) @(posedge CLK);
    check("scoreboard_drained", 80'(exp_q.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/notch_coeff_apb_regs.md
# notch_coeff_apb_regs

APB register bank that writes the coefficient, enable and bypass controls of the IIR notch filter. Software loads five shadow coefficients and then issues a commit. The block copies all five into the active set in a single cycle, aligned to a filter sample strobe, so the filter never computes with a mix of old and new coefficients. It sits between the APB interconnect and the notch filter's `filter_coeff`, `EN` and `bypass` inputs.

## Interface
- `width`, 16, coefficient width; coefficient format S16.14.
- `ADDR_W`, 8, APB address width.

- `CLK` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `PSEL` in 1: APB select.
- `PENABLE` in 1: APB access phase.
- `PWRITE` in 1: 1 = write.
- `PADDR` in `ADDR_W`: byte address; bits [1:0] ignored.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: transfer complete.
- `PSLVERR` out 1: transfer error.
- `sample_en` in 1: one-cycle sample strobe; this is the same signal that drives the filter's `EN`.
- `filter_coeff` out `5*width`: active coefficients, packed {b0,b1,b2,a1,a2}, with b0 in the MSBs.
- `filter_en` out 1: CTRL.EN.
- `bypass` out 1: CTRL.BYP.

## Operation
- Register map:
  - 0x00 CTRL (RW): bit0 EN, bit1 BYP, bit2 COMMIT (write-1 action, reads 0).
  - 0x04..0x14 shadow B0, B1, B2, A1, A2 (RW).
  - 0x18 STATUS (RO): bit0 PENDING, bits[15:8] COMMIT_CNT.
  - 0x20..0x30 active B0..A2 (RO).
- Coefficient writes use `PWDATA[width-1:0]`; upper bits are ignored. Coefficient reads are sign-extended to 32 bits.
- Commit FSM has two states, IDLE and PENDING.
  - IDLE -> PENDING on a CTRL write with bit2 = 1.
  - PENDING -> IDLE on the first edge where (`sample_en` = 1 or `filter_en` = 0). On that edge:
    - active <= shadow, all five coefficients in the same cycle;
    - COMMIT_CNT increments, wrapping 255 -> 0.
- A CTRL write with COMMIT = 1 while already PENDING updates EN/BYP, keeps PENDING, and returns no error.
- A shadow write while PENDING is rejected: PSLVERR = 1 and the shadow is unchanged. This protects the set being committed.
- PSLVERR = 1, with no state change, for:
  - an unmapped address;
  - a write to STATUS or to the active registers.
- An unmapped read returns PRDATA = 0 with PSLVERR = 1.
- Reset values:
  - shadow and active B0 = 0x4000 (1.0), all other coefficients 0, so the filter passes the signal through;
  - EN = 0, BYP = 1, PENDING = 0, COMMIT_CNT = 0;
  - PRDATA = 0, PREADY = 0, PSLVERR = 0.
- Reset mid-operation: every register returns to its reset value, and any pending commit is discarded.

## Timing
- Zero-wait-state APB.
  - PREADY = 1 exactly when `PSEL & PENABLE`, otherwise 0.
  - PSLVERR is valid only while PREADY = 1 and is 0 otherwise.
- Write: the register updates on the rising edge that ends the access phase.
  - EN and BYP become visible on their outputs on the cycle after that edge.
- Read: PRDATA is combinational from PADDR during the access phase and is 0 otherwise.
  - A read shows register state from before any edge in the same cycle.
- Commit latency:
  - A CTRL commit write at edge T sets PENDING at T.
  - The transfer happens at the first edge after T where `sample_en` = 1. A strobe coincident with T itself does not count.
  - If `filter_en` = 0 at that time, the transfer happens at edge T+1.
- `filter_coeff` changes only on a commit edge. All 80 bits change on the same edge.
- If the commit edge and a CTRL write with EN = 0 fall on the same edge, the commit still completes.

## Test plan
- Reset: after `rst_n` is released, `filter_coeff` = 0x4000_0000_0000_0000_0000, `bypass` = 1, `filter_en` = 0, and a STATUS read returns 0x0000.
- Atomic commit with filter running:
  - Write EN = 1, then B0..A2 = 0x3E00, 0x8400, 0x3E00, 0x8500, 0x3C00, then COMMIT.
  - With `sample_en` held low for 10 cycles: `filter_coeff` unchanged and PENDING = 1.
  - On the first `sample_en` pulse: `filter_coeff` = 0x3E00_8400_3E00_8500_3C00, PENDING = 0, COMMIT_CNT = 1.
- Commit with filter disabled: with EN = 0, write COMMIT -> `filter_coeff` updates one cycle later with no `sample_en`.
- Protection:
  - A shadow write while PENDING -> PSLVERR = 1, and the shadow readback still holds the old value.
  - A write to 0x18 -> PSLVERR = 1.
  - A read of 0x40 -> PSLVERR = 1, PRDATA = 0.
- Sign extension and wrap:
  - Write 0xFFFF_8000 to A1 -> A1 reads back 0xFFFF_8000.
  - After 256 commits, COMMIT_CNT = 0.
- Reset mid-commit: assert `rst_n` while PENDING -> after release, PENDING = 0 and `filter_coeff` is back at its reset value.
